// File: rtl/output_port_arbiter.sv
// Output port arbiter: packet-granular round-robin among NUM_IN queues
// feeding a single one-byte output register with valid/read handshake.
module output_port_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_last,
  output logic [NUM_IN-1:0]        in_pop,
  output logic [DATA_W-1:0]        port_out,
  output logic                     port_ready,
  input  logic                     port_read,
  output logic [NUM_IN-1:0]        grant,
  output logic                     busy,
  output logic                     pkt_err,
  output logic [15:0]              pkt_count
);

  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       g_idx;
  logic [7:0]          cnt;

  logic [NUM_IN-1:0]   pick_oh;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;
  int                  j;

  logic [DATA_W-1:0]   own_data;
  logic                own_last;
  logic                own_valid;

  logic                reg_free;
  logic                load;
  logic [7:0]          cnt_nxt;
  logic                hit_max;
  logic                pkt_end;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    j        = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!pick_any && in_valid[j]) begin
        pick_any    = 1'b1;
        pick_oh[j]  = 1'b1;
        pick_idx    = PW'(j);
      end
    end
  end

  // Select the owner's byte lane and flags through the one-hot grant.
  always_comb begin
    own_data  = '0;
    own_last  = 1'b0;
    own_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        own_data  = in_data[i*DATA_W +: DATA_W];
        own_last  = in_last[i];
        own_valid = in_valid[i];
      end
    end
  end

  assign reg_free = !port_ready || port_read;
  assign load     = (state == XFER) && reg_free && own_valid;
  assign in_pop   = load ? grant : '0;
  assign cnt_nxt  = cnt + 8'd1;
  assign hit_max  = (cnt_nxt == 8'(MAX_PKT_LEN));
  assign pkt_end  = own_last || hit_max;

  // Arbitration FSM, output register and packet bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      g_idx      <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      port_out   <= '0;
      port_ready <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_count  <= '0;
    end else begin
      pkt_err <= 1'b0;
      if (port_ready && port_read) port_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_oh;
            g_idx <= pick_idx;
            busy  <= 1'b1;
            state <= XFER;
          end
        end
        XFER: begin
          if (load) begin
            port_out   <= own_data;
            port_ready <= 1'b1;
            cnt        <= cnt_nxt;
            if (pkt_end) begin
              grant     <= '0;
              busy      <= 1'b0;
              cnt       <= '0;
              state     <= IDLE;
              pkt_count <= pkt_count + 16'd1;
              pkt_err   <= !own_last;
              rr_ptr    <= (g_idx == PW'(NUM_IN - 1)) ?
                           '0 : g_idx + PW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: arbitration order,
// backpressure, bubbles, length guard and async reset.
module tb_output_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_pop;
  logic [W-1:0]   port_out;
  logic           port_ready;
  logic           port_read;
  logic [N-1:0]   grant;
  logic           busy;
  logic           pkt_err;
  logic [15:0]    pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem   [N][64];
  logic       mlast [N][64];
  int         rd [N] = '{default: 0};
  int         wr [N];

  logic [7:0]   out_log [$];
  logic [7:0]   exp_q   [$];
  logic [N-1:0] gnt_log [$];
  int           pop_cnt [N] = '{default: 0};
  int           err_cnt = 0;

  output_port_arbiter #(
    .NUM_IN(N), .DATA_W(W), .MAX_PKT_LEN(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_pop(in_pop),
    .port_out(port_out), .port_ready(port_ready),
    .port_read(port_read), .grant(grant),
    .busy(busy), .pkt_err(pkt_err),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Queue heads presented to the DUT.
  always_comb begin
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) begin
        in_valid[i]         = 1'b1;
        in_last[i]          = mlast[i][rd[i]];
        in_data[i*W +: W]   = mem[i][rd[i]];
      end
    end
  end

  // Queue pops and output transfer log.
  always @(posedge clk) begin
    if (port_ready && port_read) out_log.push_back(port_out);
    if (|in_pop) gnt_log.push_back(grant);
    if (pkt_err) err_cnt++;
    for (int i = 0; i < N; i++) begin
      if (in_pop[i]) begin
        rd[i] <= rd[i] + 1;
        pop_cnt[i]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int q, input logic [7:0] b, input logic l);
    mem[q][wr[q]]   = b;
    mlast[q][wr[q]] = l;
    wr[q]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rd[i] != wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 100 && !(!busy && !port_ready && queues_empty())) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(n < 100), 32'd1);
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, "_len"}, 32'(out_log.size() - base), 32'(exp_q.size()));
    foreach (exp_q[k])
      if (base + k < out_log.size())
        check(tag, out_log[base + k], exp_q[k]);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) wr[i] = rd[i];
  endtask

  task automatic do_reset();
    tick();
    #2 rst_n = 1'b0;
    #1 flush();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int gb;
    int p1;
    int e0;
    rst_n     = 1'b0;
    port_read = 1'b0;
    for (int i = 0; i < N; i++) wr[i] = 0;

    tick();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", port_ready, 0);
    check("rst_out", port_out, 0);
    check("rst_count", pkt_count, 0);
    check("rst_err", pkt_err, 0);
    check("rst_pop", in_pop, 0);
    tick();
    rst_n     = 1'b1;
    port_read = 1'b1;
    tick();
    check("idle_nogrant", grant, 0);

    // single 3-byte packet from q0
    base = out_log.size();
    gb   = gnt_log.size();
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    tick();
    check("t1_grant", grant, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_ready0", port_ready, 0);
    check("t1_pop", in_pop, 4'b0001);
    tick();
    check("t1_b1", port_out, 8'hA1);
    check("t1_ready1", port_ready, 1);
    tick();
    check("t1_b2", port_out, 8'hA2);
    tick();
    check("t1_b3", port_out, 8'hA3);
    check("t1_release", grant, 0);
    check("t1_idle", busy, 0);
    check("t1_count", pkt_count, 1);
    tick();
    check("t1_empty", port_ready, 0);
    check("t1_loads", 32'(gnt_log.size() - gb), 3);
    for (int k = 0; k < 3; k++)
      if (gb + k < gnt_log.size())
        check("t1_grant_load", gnt_log[gb + k], 4'b0001);

    // pointer moved past q0: q1 wins a tie
    base = out_log.size();
    push(0, 8'h01, 1); push(1, 8'h11, 1);
    drain("t1b");
    exp_q = '{8'h11, 8'h01};
    check_log("t1b_order", base);
    check("t1b_count", pkt_count, 3);

    do_reset();

    // all four request together from reset
    base = out_log.size();
    for (int i = 0; i < N; i++) begin
      push(i, 8'((i << 4) + 1), 0);
      push(i, 8'((i << 4) + 2), 1);
    end
    drain("t2");
    exp_q = '{8'h01, 8'h02, 8'h11, 8'h12,
              8'h21, 8'h22, 8'h31, 8'h32};
    check_log("t2_order", base);
    base = out_log.size();
    push(0, 8'h03, 1); push(3, 8'h33, 1);
    drain("t2b");
    exp_q = '{8'h03, 8'h33};
    check_log("t2b_wrap", base);
    check("t2_count", pkt_count, 6);

    // backpressure, read pattern 1,0,0,1,1,0,1
    base = out_log.size();
    p1   = pop_cnt[1];
    port_read = 1'b1;
    push(1, 8'h41, 0); push(1, 8'h42, 0);
    push(1, 8'h43, 0); push(1, 8'h44, 1);
    tick();
    port_read = 1'b0;
    tick();
    check("t3_load", port_out, 8'h41);
    check("t3_ready", port_ready, 1);
    tick();
    check("t3_hold1", port_out, 8'h41);
    port_read = 1'b1;
    tick();
    tick();
    port_read = 1'b0;
    tick();
    check("t3_hold3", port_out, 8'h43);
    port_read = 1'b1;
    drain("t3");
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    check_log("t3_bytes", base);
    check("t3_pops", 32'(pop_cnt[1] - p1), 4);
    check("t3_count", pkt_count, 7);

    // bubble in q2 while q0 waits
    base = out_log.size();
    push(2, 8'h51, 0); push(2, 8'h52, 0);
    tick();
    check("t4_grant", grant, 4'b0100);
    push(0, 8'h61, 1);
    tick();
    check("t4_b1", port_out, 8'h51);
    tick();
    check("t4_b2", port_out, 8'h52);
    tick();
    check("t4_bub_ready", port_ready, 0);
    check("t4_bub_grant", grant, 4'b0100);
    tick();
    check("t4_bub_grant2", grant, 4'b0100);
    tick();
    check("t4_bub_grant3", grant, 4'b0100);
    check("t4_bub_busy", busy, 1);
    check("t4_bub_pop", in_pop, 0);
    push(2, 8'h53, 0); push(2, 8'h54, 1);
    tick();
    check("t4_b3", port_out, 8'h53);
    tick();
    check("t4_b4", port_out, 8'h54);
    check("t4_release", grant, 0);
    check("t4_noerr_at_max", pkt_err, 0);
    tick();
    check("t4_q0_grant", grant, 4'b0001);
    drain("t4");
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h61};
    check_log("t4_bytes", base);

    // length guard, 6 bytes without last
    base = out_log.size();
    e0   = err_cnt;
    for (int k = 0; k < 6; k++) push(0, 8'(8'h71 + k), 0);
    tick();
    check("t5_grant", grant, 4'b0001);
    tick(); tick(); tick();
    tick();
    check("t5_b4", port_out, 8'h74);
    check("t5_err", pkt_err, 1);
    check("t5_release", grant, 0);
    check("t5_idle", busy, 0);
    check("t5_count", pkt_count, 10);
    tick();
    check("t5_err_pulse", pkt_err, 0);
    check("t5_regrant", grant, 4'b0001);
    push(0, 8'h77, 1);
    drain("t5");
    exp_q = '{8'h71, 8'h72, 8'h73, 8'h74,
              8'h75, 8'h76, 8'h77};
    check_log("t5_bytes", base);
    check("t5_err_cnt", 32'(err_cnt - e0), 1);
    check("t5_count2", pkt_count, 11);

    // async reset mid-packet
    push(1, 8'h81, 0); push(1, 8'h82, 0);
    push(1, 8'h83, 0); push(1, 8'h84, 1);
    tick();
    check("t6_grant", grant, 4'b0010);
    tick();
    check("t6_ready", port_ready, 1);
    check("t6_b1", port_out, 8'h81);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", port_ready, 0);
    check("t6_rst_out", port_out, 0);
    check("t6_rst_count", pkt_count, 0);
    check("t6_rst_err", pkt_err, 0);
    check("t6_rst_pop", in_pop, 0);
    flush();
    tick();
    rst_n = 1'b1;
    base = out_log.size();
    push(0, 8'hA5, 1); push(1, 8'h91, 1);
    tick();
    check("t6_q0_first", grant, 4'b0001);
    drain("t6");
    exp_q = '{8'hA5, 8'h91};
    check_log("t6_bytes", base);
    check("t6_count", pkt_count, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
